// File: rtl/loop_stack.sv
// rtl/loop_stack.sv - hardware loop stack with redirect, direct top-entry writes and sticky error flags
//
// Holds up to DEPTH nested loop entries {LP, LC}. A push opens a loop, an end marker either
// redirects back to the top LP (decrementing LC) or pops the finished loop.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   push_valid/push_lp/push_count  begin-loop request with start address and iteration count
//   end_valid                  loop-end marker reached
//   wr_valid/wr_sel/wr_add/wr_data/wr_mask  masked write (or masked add to LC) of the top entry
//   err_clr                    clears sticky error flags
//   redirect/redirect_pc       combinational branch request and its target (top LP)
//   top_lp/top_lc              top entry fields, 0 when empty
//   level/full/empty           occupancy
//   overflow/underflow/collision  sticky error flags
module loop_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [WIDTH-1:0]           push_lp,
    input  logic [WIDTH-1:0]           push_count,
    input  logic                       end_valid,
    input  logic                       wr_valid,
    input  logic                       wr_sel,
    input  logic                       wr_add,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [WIDTH-1:0]           wr_mask,
    input  logic                       err_clr,
    output logic                       redirect,
    output logic [WIDTH-1:0]           redirect_pc,
    output logic [WIDTH-1:0]           top_lp,
    output logic [WIDTH-1:0]           top_lc,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       collision
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [LW-1:0]    LVL_ONE = LW'(1);
    localparam logic [LW-1:0]    LVL_MAX = LW'(DEPTH);
    localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] lp_q [DEPTH];
    logic [WIDTH-1:0] lp_d [DEPTH];
    logic [WIDTH-1:0] lc_q [DEPTH];
    logic [WIDTH-1:0] lc_d [DEPTH];
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             col_q, col_d;

    logic [LW-1:0]    level_m1;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    push_idx;
    logic             is_full, is_empty;
    logic [WIDTH-1:0] cur_lp, cur_lc;
    logic [WIDTH-1:0] wr_val;
    logic             ovf_set, unf_set, col_set;

    // Index arithmetic: top entry lives at level-1; a push lands at level (only used when not full,
    // so level < DEPTH and the truncation to IW bits is lossless).
    assign level_m1 = level_q - LVL_ONE;
    assign top_idx  = level_m1[IW-1:0];
    assign push_idx = level_q[IW-1:0];
    assign is_full  = (level_q == LVL_MAX);
    assign is_empty = (level_q == '0);
    assign cur_lp   = is_empty ? '0 : lp_q[top_idx];
    assign cur_lc   = is_empty ? '0 : lc_q[top_idx];

    assign redirect    = end_valid & ~push_valid & ~is_empty & (cur_lc > W_ONE);
    assign redirect_pc = cur_lp;
    assign top_lp      = cur_lp;
    assign top_lc      = cur_lc;
    assign level       = level_q;
    assign full        = is_full;
    assign empty       = is_empty;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign collision   = col_q;

    assign wr_val = (wr_sel && wr_add) ? (cur_lc + wr_data) : wr_data;

    assign ovf_set = push_valid & is_full;
    assign unf_set = (end_valid & ~push_valid & is_empty)
                   | (wr_valid & ~push_valid & ~end_valid & is_empty);
    assign col_set = (push_valid & end_valid) | (wr_valid & (push_valid | end_valid));

    always_comb begin
        lp_d    = lp_q;
        lc_d    = lc_q;
        level_d = level_q;

        // Push wins over end and write; end wins over write.
        if (push_valid) begin
            if (!is_full) begin
                lp_d[push_idx] = push_lp;
                lc_d[push_idx] = push_count;
                level_d        = level_q + LVL_ONE;
            end
        end else if (end_valid) begin
            if (!is_empty) begin
                if (cur_lc > W_ONE) begin
                    lc_d[top_idx] = cur_lc - W_ONE;
                end else begin
                    level_d = level_m1;
                end
            end
        end else if (wr_valid && !is_empty) begin
            if (wr_sel) begin
                lc_d[top_idx] = (cur_lc & ~wr_mask) | (wr_val & wr_mask);
            end else begin
                lp_d[top_idx] = (cur_lp & ~wr_mask) | (wr_val & wr_mask);
            end
        end

        // A same-cycle set beats err_clr.
        ovf_d = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        unf_d = unf_set ? 1'b1 : (err_clr ? 1'b0 : unf_q);
        col_d = col_set ? 1'b1 : (err_clr ? 1'b0 : col_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lp_q[i] <= '0;
                lc_q[i] <= '0;
            end
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                lp_q[i] <= lp_d[i];
                lc_q[i] <= lc_d[i];
            end
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_loop_stack.sv
// tb/tb_loop_stack.sv - scoreboard bench for loop_stack with directed cycle vectors
module tb_loop_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [15:0] push_lp;
    logic [15:0] push_count;
    logic        end_valid;
    logic        wr_valid;
    logic        wr_sel;
    logic        wr_add;
    logic [15:0] wr_data;
    logic [15:0] wr_mask;
    logic        err_clr;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] top_lp;
    logic [15:0] top_lc;
    logic [2:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;
    logic        collision;

    loop_stack #(.WIDTH(16), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_lp     (push_lp),
        .push_count  (push_count),
        .end_valid   (end_valid),
        .wr_valid    (wr_valid),
        .wr_sel      (wr_sel),
        .wr_add      (wr_add),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .err_clr     (err_clr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .top_lp      (top_lp),
        .top_lc      (top_lc),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        red;
        logic [15:0] tlp;
        logic [15:0] tlc;
        logic [2:0]  lvl;
        logic        ovf;
        logic        unf;
        logic        col;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: the outputs are valid every cycle; each issued vector owns one sampling slot.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "redirect",    16'(redirect),    16'(e.red));
            chk(e.name, "redirect_pc", redirect_pc,      e.tlp);
            chk(e.name, "top_lp",      top_lp,           e.tlp);
            chk(e.name, "top_lc",      top_lc,           e.tlc);
            chk(e.name, "level",       16'(level),       16'(e.lvl));
            chk(e.name, "full",        16'(full),        16'(e.lvl == 3'd4));
            chk(e.name, "empty",       16'(empty),       16'(e.lvl == 3'd0));
            chk(e.name, "overflow",    16'(overflow),    16'(e.ovf));
            chk(e.name, "underflow",   16'(underflow),   16'(e.unf));
            chk(e.name, "collision",   16'(collision),   16'(e.col));
        end
    end

    // Apply one cycle of inputs and queue the outputs expected during that same cycle.
    task automatic step(input string nm,
                        input logic r, input logic pv, input logic [15:0] plp, input logic [15:0] pc,
                        input logic ev, input logic wv, input logic ws, input logic wa,
                        input logic [15:0] wd, input logic [15:0] wm, input logic ec,
                        input logic e_red, input logic [15:0] e_tlp, input logic [15:0] e_tlc,
                        input logic [2:0] e_lvl, input logic e_ovf, input logic e_unf, input logic e_col);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; push_valid = pv; push_lp = plp; push_count = pc; end_valid = ev;
        wr_valid = wv; wr_sel = ws; wr_add = wa; wr_data = wd; wr_mask = wm; err_clr = ec;
        e.name = nm; e.red = e_red; e.tlp = e_tlp; e.tlc = e_tlc; e.lvl = e_lvl;
        e.ovf = e_ovf; e.unf = e_unf; e.col = e_col;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_lp = '0; push_count = '0; end_valid = 1'b0;
        wr_valid = 1'b0; wr_sel = 1'b0; wr_add = 1'b0; wr_data = '0; wr_mask = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);

        //     name        rst push lp      cnt     end wr sel add data     mask     clr  red tlp      tlc      lvl ovf unf col
        step("reset",      0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        // single loop, count 3
        step("a_push",     0, 1, 16'h0010, 16'h3, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        step("a_end1",     0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   1, 16'h0010, 16'h0003, 1, 0, 0, 0);
        step("a_end2",     0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   1, 16'h0010, 16'h0002, 1, 0, 0, 0);
        step("a_end3",     0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0010, 16'h0001, 1, 0, 0, 0);
        step("a_popped",   0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        // fill to DEPTH and overflow
        step("b_push0",    0, 1, 16'h0040, 16'h2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        step("b_push1",    0, 1, 16'h0041, 16'h2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0040, 16'h0002, 1, 0, 0, 0);
        step("b_push2",    0, 1, 16'h0042, 16'h2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0041, 16'h0002, 2, 0, 0, 0);
        step("b_push3",    0, 1, 16'h0043, 16'h2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0042, 16'h0002, 3, 0, 0, 0);
        step("b_push4",    0, 1, 16'h0050, 16'h2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0043, 16'h0002, 4, 0, 0, 0);
        step("b_ovf",      0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0043, 16'h0002, 4, 1, 0, 0);
        step("b_clr",      0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1,   0, 16'h0043, 16'h0002, 4, 1, 0, 0);
        step("b_end1",     0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   1, 16'h0043, 16'h0002, 4, 0, 0, 0);
        step("b_end2",     0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0043, 16'h0001, 4, 0, 0, 0);
        // end + write collide at level 3, then reset alongside a push
        step("b_endwr",    0, 0, 16'h0000, 16'h0, 1, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0,   1, 16'h0042, 16'h0002, 3, 0, 0, 0);
        step("b_rstpush",  1, 1, 16'h0099, 16'h5, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0042, 16'h0001, 3, 0, 0, 1);
        step("b_afterrst", 0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        // underflow from end on empty (previous step) and from write on empty
        step("c_unf",      0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1,   0, 16'h0000, 16'h0000, 0, 0, 1, 0);
        step("c_cleared",  0, 0, 16'h0000, 16'h0, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0,   0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        step("c_wrunf",    0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1,   0, 16'h0000, 16'h0000, 0, 0, 1, 0);
        step("c_setbeats", 0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1,   0, 16'h0000, 16'h0000, 0, 0, 1, 0);
        // nested loops
        step("d_push20",   0, 1, 16'h0020, 16'h2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        step("d_push30",   0, 1, 16'h0030, 16'h2, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0020, 16'h0002, 1, 0, 0, 0);
        step("d_end30a",   0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   1, 16'h0030, 16'h0002, 2, 0, 0, 0);
        step("d_end30b",   0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0030, 16'h0001, 2, 0, 0, 0);
        step("d_end20",    0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   1, 16'h0020, 16'h0002, 1, 0, 0, 0);
        // direct writes to the top entry
        step("e_wrlc",     0, 0, 16'h0000, 16'h0, 0, 1, 1, 0, 16'h00F0, 16'hFFFF, 0,   0, 16'h0020, 16'h0001, 1, 0, 0, 0);
        step("e_wradd",    0, 0, 16'h0000, 16'h0, 0, 1, 1, 1, 16'h0020, 16'h00FF, 0,   0, 16'h0020, 16'h00F0, 1, 0, 0, 0);
        step("e_wrlp",     0, 0, 16'h0000, 16'h0, 0, 1, 0, 0, 16'hABCD, 16'h0F0F, 0,   0, 16'h0020, 16'h0010, 1, 0, 0, 0);
        step("e_pushend",  0, 1, 16'h0060, 16'h7, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0B2D, 16'h0010, 1, 0, 0, 0);
        step("e_col",      0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1,   0, 16'h0060, 16'h0007, 2, 0, 0, 1);
        step("e_end60",    0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0,   1, 16'h0060, 16'h0007, 2, 0, 0, 0);
        step("e_final",    0, 0, 16'h0000, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,   0, 16'h0060, 16'h0006, 2, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loop_stack.md
LOOP_STACK -- requirements
Module: loop_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the word width of loop pointer, count and data paths.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the maximum number of nested loop entries (>=2).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port push_valid  input  1  begin-loop request.
REQ-006 SHALL have port push_lp  input  WIDTH  loop-start address to store.
REQ-007 SHALL have port push_count  input  WIDTH  iteration count to store.
REQ-008 SHALL have port end_valid  input  1  loop-end marker reached.
REQ-009 SHALL have port wr_valid  input  1  direct write to the top entry.
REQ-010 SHALL have port wr_sel  input  1  write target: 0 = LP, 1 = LC.
REQ-011 SHALL have port wr_add  input  1  when 1 and wr_sel=1, the written value is LC+wr_data.
REQ-012 SHALL have port wr_data  input  WIDTH  write data.
REQ-013 SHALL have port wr_mask  input  WIDTH  per-bit write enable.
REQ-014 SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-015 SHALL have port redirect  output  1  take a branch to redirect_pc this cycle (combinational).
REQ-016 SHALL have port redirect_pc  output  WIDTH  branch target; equals top LP.
REQ-017 SHALL have port top_lp  output  WIDTH  LP of the top entry; 0 when empty.
REQ-018 SHALL have port top_lc  output  WIDTH  LC of the top entry; 0 when empty.
REQ-019 SHALL have port level  output  $clog2(DEPTH+1)  number of valid entries.
REQ-020 SHALL have port full, empty  output  1 each  level==DEPTH, level==0.
REQ-021 SHALL have port overflow, underflow, collision  output  1 each  sticky error flags.

Function
REQ-022 SHALL keep the stack state in registers: DEPTH x {LP, LC} plus the level counter; the top entry is index level-1.
REQ-023 SHALL, when push_valid, end_valid=0 and not full, write {push_lp, push_count} to index level and increment level on the next edge.
REQ-024 SHALL, when push_valid while full, leave the stack unchanged and set overflow.
REQ-025 SHALL, when end_valid, push_valid=0, not empty and top LC>1, assert redirect in the same cycle and decrement top LC by 1 on the next edge.
REQ-026 SHALL, when end_valid, push_valid=0, not empty and top LC<=1, keep redirect=0 and pop the entry (level-1) on the next edge.
REQ-027 SHALL, when end_valid while empty, keep redirect=0, leave the stack unchanged and set underflow.
REQ-028 SHALL, when push_valid and end_valid are both high, perform the push only (subject to REQ-023/024), keep redirect=0 and set collision.
REQ-029 SHALL, when wr_valid is high with neither push nor end, update the selected field of the top entry bitwise: new = (old & ~wr_mask) | (val & wr_mask), where val = wr_data, or old LC + wr_data (modulo 2^WIDTH) when wr_add and wr_sel=1.
REQ-030 SHALL ignore wr_valid when it coincides with push_valid or end_valid, and set collision in that case.
REQ-031 SHALL, when wr_valid with the stack empty, make no state change and set underflow.
REQ-032 SHALL drive redirect_pc from the top LP at all times.
REQ-033 SHALL give err_clr lower priority than a same-cycle error set: the flag stays 1.
REQ-034 SHALL produce no X on outputs for any input combination once reset has been applied.

Reset
REQ-035 SHALL, when rst is high at an edge, set level=0, all LP/LC entries to 0 and overflow/underflow/collision to 0, overriding all other inputs.
REQ-036 SHALL, if reset occurs mid-loop, discard all pending entries; redirect is 0 in the cycle after the reset edge.

Verification
REQ-037 SHALL cover: WIDTH=16, DEPTH=4; push(lp=0x10, count=3), then end x3 -> redirect=1, 1, 0 with redirect_pc=0x10; level goes 1,1,1,0.
REQ-038 SHALL cover: 4 pushes (count=2 each) -> full=1; a 5th push -> overflow=1, level stays 4, top_lp unchanged.
REQ-039 SHALL cover: end on an empty stack -> redirect=0, underflow=1; err_clr -> underflow=0 on the next cycle.
REQ-040 SHALL cover: nested push(0x20,2) and push(0x30,2); end, end -> redirect to 0x30 then pop; end -> redirect to 0x20 with top_lc going 2 to 1.
REQ-041 SHALL cover: top LC=0x00F0; wr_valid, wr_sel=1, wr_add=1, wr_data=0x0020, wr_mask=0x00FF -> top_lc=0x0010; push+end in the same cycle -> push only, collision=1.
REQ-042 SHALL cover: rst asserted with level=3 alongside a push -> level=0, all flags 0, top_lp=top_lc=0.
